gpio_ahb_irq: RTL

Parametrised AHB-Lite GPIO slave, successor to the basic AHB GPIO.
- Adds a configurable input synchroniser and atomic set/clear/toggle of outputs.
- Adds per-pin interrupts: edge/level, polarity and both-edge modes, with a W1C status register.
- Sits on the AHB peripheral bus and drives one IRQ line to the interrupt controller.

---
 rtl/gpio_ahb_irq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/gpio_ahb_irq.sv
// AHB-Lite GPIO slave: input synchroniser, atomic set/clear/toggle, per-pin edge/level IRQs with W1C status.
// Latency: writes land at end of data phase, reads combinational in data phase, gpi->irq sync_stages+1 clocks.
// Backpressure: hready held 1; with GPIO_AHB_IRQ_ERR_RESP_EN a bad transfer gets a two-cycle ERROR (hready low once).
module gpio_ahb_irq #(
    parameter int gpio_w      = 8,
    parameter int sync_stages = 2
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [5:0]        haddr,
    output logic [31:0]       hrdata,
    input  logic [31:0]       hwdata,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    output logic [1:0]        hresp,
    output logic              hready,
    input  logic              hsel,
    output logic              irq,
    input  logic [gpio_w-1:0] gpi,
    output logic [gpio_w-1:0] gpo,
    output logic [gpio_w-1:0] gpd
);
    localparam logic [3:0] A_GPI   = 4'h0;
    localparam logic [3:0] A_GPO   = 4'h1;
    localparam logic [3:0] A_GPD   = 4'h2;
    localparam logic [3:0] A_SET   = 4'h3;
    localparam logic [3:0] A_CLR   = 4'h4;
    localparam logic [3:0] A_TGL   = 4'h5;
    localparam logic [3:0] A_EN    = 4'h6;
    localparam logic [3:0] A_LVL   = 4'h7;
    localparam logic [3:0] A_POL   = 4'h8;
    localparam logic [3:0] A_BOTH  = 4'h9;
    localparam logic [3:0] A_STAT  = 4'hA;
    localparam logic [3:0] A_MSTAT = 4'hB;

    logic              dp_vld, dp_write, wr, accept, err_req;
    logic [3:0]        dp_idx;
    logic [gpio_w-1:0] wd, w1c;
    logic [gpio_w-1:0] gpo_q, gpd_q, en_q, lvl_q, pol_q, both_q, stat_q;
    logic [gpio_w-1:0] sync_q [sync_stages];
    logic [gpio_w-1:0] gs, gp_q, rise, fall, edge_hit, lvl_hit, set_cond;
    logic [31:0]       rd_val;
    logic              unused_ok;

    assign unused_ok = ^{hburst, hsize, haddr[1:0], hwdata};

    assign accept = hsel && htrans[1] && hready;
    assign wd     = hwdata[gpio_w-1:0];
    assign wr     = dp_vld && dp_write;
    assign w1c    = (wr && dp_idx == A_STAT) ? wd : '0;

`ifdef GPIO_AHB_IRQ_ERR_RESP_EN
    typedef enum logic [1:0] {ERR_IDLE, ERR_FIRST, ERR_SECOND} err_t;
    err_t       err_st;
    logic       hready_q;
    logic [1:0] hresp_q;

    assign err_req = (haddr[5:2] >= 4'hC) || (hsize != 3'b010) ||
                     (hwrite && (haddr[5:2] == A_GPI || haddr[5:2] == A_MSTAT));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            err_st   <= ERR_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
        end else begin
            case (err_st)
                ERR_FIRST: begin
                    err_st   <= ERR_SECOND;
                    hready_q <= 1'b1;
                    hresp_q  <= 2'b01;
                end
                default: begin
                    // A new transfer may be accepted in the second error cycle
                    if (accept && err_req) begin
                        err_st   <= ERR_FIRST;
                        hready_q <= 1'b0;
                        hresp_q  <= 2'b01;
                    end else begin
                        err_st   <= ERR_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 2'b00;
                    end
                end
            endcase
        end
    end

    assign hready = hready_q;
    assign hresp  = hresp_q;
`else
    assign err_req = 1'b0;
    assign hready  = 1'b1;
    assign hresp   = 2'b00;
`endif

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= 4'h0;
        end else begin
            dp_vld <= accept && !err_req;
            if (accept) begin
                dp_write <= hwrite;
                dp_idx   <= haddr[5:2];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
            gp_q <= '0;
        end else begin
            sync_q[0] <= gpi;
            for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
            gp_q <= gs;
        end
    end

    assign gs       = sync_q[sync_stages-1];
    assign rise     = gs & ~gp_q;
    assign fall     = ~gs & gp_q;
    assign edge_hit = (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
    assign lvl_hit  = (pol_q & gs) | (~pol_q & ~gs);
    assign set_cond = en_q & ((lvl_q & lvl_hit) | (~lvl_q & edge_hit));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            gpo_q  <= '0;
            gpd_q  <= '0;
            en_q   <= '0;
            lvl_q  <= '0;
            pol_q  <= '0;
            both_q <= '0;
            stat_q <= '0;
        end else begin
            // Set is OR'ed after the clear so a same-cycle event is never lost
            stat_q <= (stat_q & ~w1c) | set_cond;
            if (wr) begin
                case (dp_idx)
                    A_GPO:   gpo_q  <= wd;
                    A_GPD:   gpd_q  <= wd;
                    A_SET:   gpo_q  <= gpo_q | wd;
                    A_CLR:   gpo_q  <= gpo_q & ~wd;
                    A_TGL:   gpo_q  <= gpo_q ^ wd;
                    A_EN:    en_q   <= wd;
                    A_LVL:   lvl_q  <= wd;
                    A_POL:   pol_q  <= wd;
                    A_BOTH:  both_q <= wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = 32'h0;
        case (dp_idx)
            A_GPI:   rd_val = 32'(gs);
            A_GPO:   rd_val = 32'(gpo_q);
            A_GPD:   rd_val = 32'(gpd_q);
            A_EN:    rd_val = 32'(en_q);
            A_LVL:   rd_val = 32'(lvl_q);
            A_POL:   rd_val = 32'(pol_q);
            A_BOTH:  rd_val = 32'(both_q);
            A_STAT:  rd_val = 32'(stat_q);
            A_MSTAT: rd_val = 32'(stat_q & en_q);
            default: rd_val = 32'h0;
        endcase
    end

    assign hrdata = (dp_vld && !dp_write) ? rd_val : 32'h0;
    assign irq    = |(stat_q & en_q);
    assign gpo    = gpo_q;
    assign gpd    = gpd_q;
endmodule
